// File: rtl/wb_merge_buffer_pkg.sv
// Shared types and default widths for the write-back merge buffer.
// The default entry layout is {uses_rw, rw_addr, rw_data, id}.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

package wb_merge_buffer_pkg;

    localparam int unsigned WB_RADDR_W = 5;
    localparam int unsigned WB_DATA_W  = 32;
    localparam int unsigned WB_ID_W    = `ADDR_WIDTH;

    typedef struct packed {
        logic                  uses_rw;
        logic [WB_RADDR_W-1:0] rw_addr;
        logic [WB_DATA_W-1:0]  rw_data;
        logic [WB_ID_W-1:0]    id;
    } wb_entry_t;

endpackage

// File: rtl/wb_merge_buffer_if.sv
// Completion-channel inputs and the merged write-back output of the merge buffer.
// The slave modport is the buffer; the master modport is the producers and the consumer.
interface wb_merge_buffer_if #(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RADDR_W = 5,
    parameter int unsigned ID_W    = 8,
    parameter int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic [NUM_CH-1:0]         in_valid;
    logic [NUM_CH-1:0]         in_ready;
    logic [NUM_CH-1:0]         in_uses_rw;
    logic [NUM_CH*RADDR_W-1:0] in_rw_addr;
    logic [NUM_CH*DATA_W-1:0]  in_rw_data;
    logic [NUM_CH*ID_W-1:0]    in_id;
    logic                      out_valid;
    logic                      out_ready;
    logic                      out_uses_rw;
    logic [RADDR_W-1:0]        out_rw_addr;
    logic [DATA_W-1:0]         out_rw_data;
    logic [ID_W-1:0]           out_id;
    logic [CH_W-1:0]           out_ch;
    logic                      overflow_err;

    modport slave (
        input  in_valid, in_uses_rw, in_rw_addr, in_rw_data, in_id, out_ready,
        output in_ready, out_valid, out_uses_rw, out_rw_addr, out_rw_data, out_id,
               out_ch, overflow_err
    );

    modport master (
        output in_valid, in_uses_rw, in_rw_addr, in_rw_data, in_id, out_ready,
        input  in_ready, out_valid, out_uses_rw, out_rw_addr, out_rw_data, out_id,
               out_ch, overflow_err
    );
endinterface

// File: rtl/wb_merge_buffer_fifo.sv
// Per-channel completion FIFO; full/empty come from the registered count only.
// Pushes while full and pops while empty are ignored.
import wb_merge_buffer_pkg::*;

module wb_chan_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter type T = wb_entry_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  T     din,
    output logic full,
    output logic empty,
    output T     head
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == (PTR_W + 1)'(DEPTH));
    assign empty = (count == '0);
    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/wb_merge_buffer.sv
// Merges NUM_CH completion channels into one registered write-back port
// using per-channel FIFOs and a round-robin arbiter.
import wb_merge_buffer_pkg::*;

module wb_merge_buffer #(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned DATA_W  = WB_DATA_W,
    parameter int unsigned RADDR_W = WB_RADDR_W,
    parameter int unsigned ID_W    = WB_ID_W
) (
    input logic           clk,
    input logic           rst,
    wb_merge_buffer_if.slave bus
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef struct packed {
        logic               uses_rw;
        logic [RADDR_W-1:0] rw_addr;
        logic [DATA_W-1:0]  rw_data;
        logic [ID_W-1:0]    id;
    } entry_t;

    entry_t              heads [NUM_CH];
    logic [NUM_CH-1:0]   full;
    logic [NUM_CH-1:0]   empty;
    logic [NUM_CH-1:0]   push;
    logic [NUM_CH-1:0]   pop;
    logic [2*NUM_CH-1:0] rot;
    logic [CH_W-1:0]     rr_ptr;
    logic [CH_W-1:0]     grant;
    logic                found;
    logic                ld;
    entry_t              sel;
    entry_t              out_q;
    logic                out_valid_q;
    logic [CH_W-1:0]     out_ch_q;
    logic                overflow_q;
    int unsigned         idx;

    assign ld = ~out_valid_q | bus.out_ready;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        entry_t din;
        assign din = '{uses_rw: bus.in_uses_rw[i],
                       rw_addr: bus.in_rw_addr[i*RADDR_W +: RADDR_W],
                       rw_data: bus.in_rw_data[i*DATA_W +: DATA_W],
                       id:      bus.in_id[i*ID_W +: ID_W]};
        assign push[i] = bus.in_valid[i] & ~full[i];
        assign pop[i]  = ld & found & (grant == CH_W'(i));

        wb_chan_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[i]),
            .pop   (pop[i]),
            .din   (din),
            .full  (full[i]),
            .empty (empty[i]),
            .head  (heads[i])
        );
    end

    // Rotating the doubled request vector by rr_ptr puts the highest-priority
    // channel at bit 0; the first set bit is then the offset from rr_ptr.
    always_comb begin
        rot   = {~empty, ~empty} >> rr_ptr;
        found = 1'b0;
        grant = '0;
        idx   = 0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                idx   = 32'(rr_ptr) + k;
                if (idx >= NUM_CH) idx = idx - NUM_CH;
                grant = CH_W'(idx);
            end
        end
    end

    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (grant == CH_W'(i)) sel = heads[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            out_ch_q    <= '0;
            rr_ptr      <= '0;
            overflow_q  <= 1'b0;
        end else begin
            overflow_q <= overflow_q | (|(bus.in_valid & full));
            if (ld) begin
                if (found) begin
                    out_valid_q   <= 1'b1;
                    out_q         <= sel;
                    out_q.uses_rw <= sel.uses_rw & (sel.rw_addr != '0);
                    out_ch_q      <= grant;
                    rr_ptr        <= (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready     = ~full;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_uses_rw  = out_q.uses_rw;
    assign bus.out_rw_addr  = out_q.rw_addr;
    assign bus.out_rw_data  = out_q.rw_data;
    assign bus.out_id       = out_q.id;
    assign bus.out_ch       = out_ch_q;
    assign bus.overflow_err = overflow_q;
endmodule

// File: tb/tb_wb_merge_buffer.sv
// Directed and randomized checks of wb_merge_buffer against a queue-based
// reference model of the merge/arbitration rules.
module tb_wb_merge_buffer;
    localparam int NUM_CH  = 2;
    localparam int DEPTH   = 4;
    localparam int DATA_W  = 32;
    localparam int RADDR_W = 5;
    localparam int ID_W    = 8;
    localparam int CH_W    = 1;

    typedef struct packed {
        logic               uses_rw;
        logic [RADDR_W-1:0] rw_addr;
        logic [DATA_W-1:0]  rw_data;
        logic [ID_W-1:0]    id;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    ent_t q [NUM_CH][$];
    bit   m_valid;
    ent_t m_ent;
    int   m_ch;
    int   m_rr;
    bit   m_ovf;

    wb_merge_buffer_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .RADDR_W(RADDR_W),
                         .ID_W(ID_W), .CH_W(CH_W)) bus ();

    wb_merge_buffer #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .DATA_W(DATA_W),
                      .RADDR_W(RADDR_W), .ID_W(ID_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int ch, input bit v, input bit uses, input int addr,
                          input logic [DATA_W-1:0] data, input int id);
        bus.in_valid[ch]                        = v;
        bus.in_uses_rw[ch]                      = uses;
        bus.in_rw_addr[ch*RADDR_W +: RADDR_W]   = RADDR_W'(addr);
        bus.in_rw_data[ch*DATA_W +: DATA_W]     = data;
        bus.in_id[ch*ID_W +: ID_W]              = ID_W'(id);
    endtask

    task automatic clear_in();
        for (int c = 0; c < NUM_CH; c++) set_ch(c, 0, 0, 0, '0, 0);
    endtask

    // One clock: advance the model from pre-edge state and inputs, then compare.
    task automatic step();
        bit   ready [NUM_CH];
        int   g;
        int   c;
        ent_t e;
        logic [NUM_CH-1:0] exp_ready;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) q[i].delete();
            m_valid = 0; m_ent = '0; m_ch = 0; m_rr = 0; m_ovf = 0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) ready[i] = (q[i].size() < DEPTH);
            if (!m_valid || bus.out_ready) begin
                g = -1;
                for (int k = 0; k < NUM_CH; k++) begin
                    c = (m_rr + k) % NUM_CH;
                    if (g < 0 && q[c].size() > 0) g = c;
                end
                if (g >= 0) begin
                    m_ent = q[g].pop_front();
                    if (m_ent.rw_addr == 0) m_ent.uses_rw = 0;
                    m_ch    = g;
                    m_rr    = (g + 1) % NUM_CH;
                    m_valid = 1;
                end else begin
                    m_valid = 0;
                end
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (bus.in_valid[i]) begin
                    e = '{uses_rw: bus.in_uses_rw[i],
                          rw_addr: bus.in_rw_addr[i*RADDR_W +: RADDR_W],
                          rw_data: bus.in_rw_data[i*DATA_W +: DATA_W],
                          id:      bus.in_id[i*ID_W +: ID_W]};
                    if (ready[i]) q[i].push_back(e);
                    else m_ovf = 1;
                end
            end
        end
        #1;
        for (int i = 0; i < NUM_CH; i++) exp_ready[i] = (q[i].size() < DEPTH);
        check("out_valid", 64'(bus.out_valid), 64'(m_valid));
        check("in_ready", 64'(bus.in_ready), 64'(exp_ready));
        check("overflow_err", 64'(bus.overflow_err), 64'(m_ovf));
        if (m_valid) begin
            check("out_uses_rw", 64'(bus.out_uses_rw), 64'(m_ent.uses_rw));
            check("out_rw_addr", 64'(bus.out_rw_addr), 64'(m_ent.rw_addr));
            check("out_rw_data", 64'(bus.out_rw_data), 64'(m_ent.rw_data));
            check("out_id", 64'(bus.out_id), 64'(m_ent.id));
            check("out_ch", 64'(bus.out_ch), 64'(m_ch));
        end
    endtask

    initial begin
        // Reset held 3 cycles with every channel trying to push.
        rst = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < NUM_CH; c++) set_ch(c, 1, 1, 3 + c, 32'h1111_0000 + c, 16 + c);
        repeat (3) step();
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'(bus.out_rw_data), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'h3);
        check("rst_overflow", 64'(bus.overflow_err), 64'd0);
        rst = 1'b0;
        clear_in();
        repeat (3) step();

        // Single entry: two-edge latency, then the output empties again.
        set_ch(0, 1, 1, 5, 32'hDEAD_BEEF, 8'h40);
        step();
        clear_in();
        check("single_not_yet", 64'(bus.out_valid), 64'd0);
        step();
        check("single_valid", 64'(bus.out_valid), 64'd1);
        check("single_data", 64'(bus.out_rw_data), 64'hDEAD_BEEF);
        check("single_id", 64'(bus.out_id), 64'h40);
        check("single_ch", 64'(bus.out_ch), 64'd0);
        step();
        check("single_gone", 64'(bus.out_valid), 64'd0);

        // Fairness: both channels push every cycle.
        for (int n = 0; n < 8; n++) begin
            set_ch(0, 1, 1, 1 + n, 32'hA000_0000 + n, n);
            set_ch(1, 1, 1, 9 + n, 32'hB000_0000 + n, 128 + n);
            step();
        end
        clear_in();
        repeat (12) step();

        // Backpressure: output stalls, ch1 fills and then overflows.
        bus.out_ready = 1'b0;
        for (int n = 0; n < 6; n++) begin
            set_ch(1, 1, 1, 20 + n, 32'hC000_0000 + n, 64 + n);
            step();
            if (n == 4) check("bp_full", 64'(bus.in_ready[1]), 64'd0);
        end
        clear_in();
        check("bp_overflow", 64'(bus.overflow_err), 64'd1);
        bus.out_ready = 1'b1;
        repeat (7) step();

        // $zero destination suppresses the register write.
        set_ch(0, 1, 1, 0, 32'd7, 9);
        step();
        clear_in();
        step();
        check("zero_valid", 64'(bus.out_valid), 64'd1);
        check("zero_uses_rw", 64'(bus.out_uses_rw), 64'd0);
        check("zero_id", 64'(bus.out_id), 64'd9);
        step();

        // Mid-stream reset with buffered entries and a held output.
        bus.out_ready = 1'b0;
        for (int n = 0; n < 4; n++) begin
            set_ch(0, 1, 1, 2 + n, 32'hE000_0000 + n, 200 + n);
            step();
        end
        clear_in();
        check("mid_pre_valid", 64'(bus.out_valid), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_overflow", 64'(bus.overflow_err), 64'd0);
        bus.out_ready = 1'b1;
        repeat (6) step();

        // Randomized traffic, backpressure and occasional resets.
        for (int n = 0; n < 800; n++) begin
            for (int c = 0; c < NUM_CH; c++)
                set_ch(c, ($urandom_range(0, 1) == 1), $urandom_range(0, 1) == 1,
                       int'($urandom_range(0, 31)), $urandom, int'($urandom_range(0, 255)));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;
        clear_in();
        bus.out_ready = 1'b1;
        repeat (12) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
